// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the round engine: FSM states, round count,
// S-box table and GF(2^8) helpers.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINISH} fsm_t;

    localparam int NROUNDS = 10;

    // Element [15] holds byte 0 (the MSB byte of the 128-bit block).
    typedef logic [15:0][7:0] state_bytes_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3) rewritten around the column parity.
    function automatic logic [31:0] mix_column(logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = col;
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction

endpackage

// File: rtl/aes_sub_byte.sv
// Single-byte AES S-box lookup, purely combinational.
module aes_sub_byte
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor: one round per clock, round keys supplied externally.
// Define AES_ROUND_DEBUG_EN to expose the state register and round counter.
module aes_round_engine
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    input  logic [127:0] rk1,
    input  logic [127:0] rk2,
    input  logic [127:0] rk3,
    input  logic [127:0] rk4,
    input  logic [127:0] rk5,
    input  logic [127:0] rk6,
    input  logic [127:0] rk7,
    input  logic [127:0] rk8,
    input  logic [127:0] rk9,
    input  logic [127:0] rk10,
    output logic         busy,
    output logic         done,
    output logic [127:0] cyphertext
`ifdef AES_ROUND_DEBUG_EN
    ,
    output logic [127:0] round_state,
    output logic [3:0]   round_idx
`endif
);

    localparam logic [3:0] LAST = 4'(NROUNDS);

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] state_q, state_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] rk, sr, mc, rnd_out;
    state_bytes_t sb;

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sub_byte u_sub (.din(state_q[127-8*i -: 8]), .dout(sb[15-i]));
    end

    always_comb begin
        case (round_q)
            4'd1:    rk = rk1;
            4'd2:    rk = rk2;
            4'd3:    rk = rk3;
            4'd4:    rk = rk4;
            4'd5:    rk = rk5;
            4'd6:    rk = rk6;
            4'd7:    rk = rk7;
            4'd8:    rk = rk8;
            4'd9:    rk = rk9;
            4'd10:   rk = rk10;
            default: rk = '0;
        endcase
    end

    // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(4*c+r) -: 8] = sb[15-(4*((c+r)%4)+r)];
        for (int c = 0; c < 4; c++)
            mc[127-32*c -: 32] = mix_column(sr[127-32*c -: 32]);
    end

    assign rnd_out = ((round_q == LAST) ? sr : mc) ^ rk;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        state_d = state_q;
        ct_d    = ct_q;
        case (fsm_q)
            IDLE, FINISH: begin
                fsm_d = IDLE;
                if (start) begin
                    state_d = plaintext ^ key;
                    round_d = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (round_q == 4'd0 || round_q > LAST) begin
                    fsm_d   = IDLE;
                    round_d = 4'd0;
                end else begin
                    state_d = rnd_out;
                    if (round_q == LAST) begin
                        ct_d    = rnd_out;
                        round_d = 4'd0;
                        fsm_d   = FINISH;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            fsm_q   <= IDLE;
            round_q <= 4'd0;
            state_q <= '0;
            ct_q    <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
            ct_q    <= ct_d;
        end
    end

    assign busy       = (fsm_q == ROUND);
    assign done       = (fsm_q == FINISH);
    assign cyphertext = ct_q;

`ifdef AES_ROUND_DEBUG_EN
    assign round_state = state_q;
    assign round_idx   = round_q;
`endif

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: reference AES-128 model built from GF(2^8) maths,
// cycle-level transaction model, and directed known-answer vectors.
module tb_aes_round_engine;

    localparam logic [127:0] KA = 128'h5468617473206d79204b756e67204675;
    localparam logic [127:0] PA = 128'h54776f204f6e65204e696e652054776f;
    localparam logic [127:0] CA = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic [127:0] rkv [1:10];
    logic         busy, done;
    logic [127:0] cyphertext;
`ifdef AES_ROUND_DEBUG_EN
    logic [127:0] round_state;
    logic [3:0]   round_idx;
`endif

    aes_round_engine dut (
        .clk(clk), .nreset(nreset), .start(start),
        .plaintext(plaintext), .key(key),
        .rk1(rkv[1]), .rk2(rkv[2]), .rk3(rkv[3]), .rk4(rkv[4]), .rk5(rkv[5]),
        .rk6(rkv[6]), .rk7(rkv[7]), .rk8(rkv[8]), .rk9(rkv[9]), .rk10(rkv[10]),
        .busy(busy), .done(done), .cyphertext(cyphertext)
`ifdef AES_ROUND_DEBUG_EN
        , .round_state(round_state), .round_idx(round_idx)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference maths: S-box derived from field inverse + affine map.
    logic [7:0] sbt [256];

    function automatic logic [7:0] xt(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = xt(a);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                     {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(logic [127:0] k, int idx);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
    endfunction

    function automatic logic [127:0] aes_ref(logic [127:0] pt, logic [127:0] k);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] s;
        s = pt ^ k;
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbt[s[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = b[4*((c+row)%4)+row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = t[i];
            s = s ^ round_key(k, r);
        end
        return s;
    endfunction

    // Transaction model: result appears 10 edges after the accepting edge.
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_cnt = 0;
    logic [127:0] m_ct = '0;
    logic [127:0] m_res = '0;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_ct = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == 10) begin
                    m_busy = 1'b0; m_ct = m_res; m_done = 1'b1;
                end
            end else if (start) begin
                m_busy = 1'b1; m_cnt = 0; m_res = aes_ref(plaintext, key);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc busy", busy, m_busy);
            chk("cyc done", done, m_done);
            chk("cyc cyphertext", cyphertext, m_ct);
        end
    end

    task automatic load(input logic [127:0] pt, input logic [127:0] k);
        plaintext = pt;
        key = k;
        for (int i = 1; i <= 10; i++) rkv[i] = round_key(k, i);
    endtask

    // Called at a negedge; edges counts the accept edge as the first.
    task automatic run_one(input string name, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp_ct, input int pulse_at, input bit dbg);
        int edges;
        load(pt, k);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        plaintext = ~pt;
        while (!done && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = (edges == pulse_at);
            if (dbg && edges == 2) begin
`ifdef AES_ROUND_DEBUG_EN
                chk({name, " round_state r1"}, round_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
                chk({name, " round_idx"}, 128'(round_idx), 128'd2);
`endif
            end
        end
        start = 1'b0;
        chk({name, " latency"}, 128'(edges), 128'd11);
        chk({name, " result"}, cyphertext, exp_ct);
    endtask

    initial begin
        int last, cyc, ndone;
        for (int i = 1; i <= 10; i++) rkv[i] = '0;
        build_sbox();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset cyphertext", cyphertext, 128'd0);
        chk("model sbox 00", 128'(sbt[0]), 128'h63);
        chk("model sbox 53", 128'(sbt[8'h53]), 128'hed);
        chk("model rk10", round_key(KB, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("model vecA", aes_ref(PA, KA), CA);
        chk("model vecB", aes_ref(PB, KB), CB);
        @(negedge clk);
        nreset = 1'b1;
        run_one("vecA", PA, KA, CA, 0, 1'b0);
        @(negedge clk);
        run_one("vecB", PB, KB, CB, 0, 1'b1);
        run_one("vecA restart-ignored", PA, KA, CA, 5, 1'b0);

        // Reset mid-encryption, then a fresh start on the first released edge.
        load(PA, KA);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("midreset busy", 128'(busy), 128'd0);
        chk("midreset done", 128'(done), 128'd0);
        chk("midreset cyphertext", cyphertext, 128'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        run_one("vecB after reset", PB, KB, CB, 0, 1'b0);

        // start held high: done cycles 12 apart counting both done cycles.
        @(negedge clk);
        load(PB, KB);
        start = 1'b1;
        last = -1; cyc = 0; ndone = 0;
        while (ndone < 3 && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) begin
                chk("b2b result", cyphertext, CB);
                if (last >= 0) chk("b2b period", 128'(cyc - last + 1), 128'd12);
                last = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        chk("b2b done count", 128'(ndone), 128'd3);
        repeat (14) @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
